adder_sched: RTL and testbench
==============================

ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, operand width of the shared adder.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  NUM_REQ*WIDTH  packed operand A, requester i at slice i.
REQ-007 SHALL have port req_b  input  NUM_REQ*WIDTH  packed operand B, requester i at slice i.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port add_a  output  WIDTH  operand A driven to the shared adder.
REQ-010 SHALL have port add_b  output  WIDTH  operand B driven to the shared adder.
REQ-011 SHALL have port add_s  input  WIDTH  sum returned by the shared adder, combinational.
REQ-012 SHALL have port add_c  input  1  carry-out returned by the shared adder.
REQ-013 SHALL have port rsp_valid  output  1  result available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port rsp_sum  output  WIDTH+1  {carry, sum} of the granted operation.
REQ-016 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester that owns rsp_sum.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 In IDLE with any req_valid set: grant one requester round-robin, pulse its req_ready for exactly that cycle, register its operands onto add_a/add_b, and register its index; next state EXEC.
REQ-019 In IDLE with no req_valid: req_ready all zero, stay in IDLE.
REQ-020 Round-robin: search starts at pointer ptr, wraps from NUM_REQ-1 to 0; on grant of k, ptr becomes (k+1) mod NUM_REQ.
REQ-021 In EXEC: hold add_a/add_b stable, capture {add_c, add_s} into rsp_sum; next state RESP.
REQ-022 In RESP: rsp_valid high, rsp_sum/rsp_id stable until rsp_ready is sampled high; then return to IDLE, rsp_valid low next cycle.
REQ-023 Latency: grant at cycle N gives rsp_valid at N+2; minimum 3 cycles per operation.
REQ-024 req_ready SHALL never be asserted outside IDLE or for a requester whose req_valid is low.
REQ-025 Requester whose req_valid drops before grant SHALL be skipped without side effect.
REQ-026 add_a/add_b SHALL retain the last granted operands in all states other than IDLE-grant.
REQ-027 Carry: 4'd15 + 4'd1 SHALL yield rsp_sum 5'b1_0000.

Reset
REQ-028 On rst_n low, immediately: state IDLE, ptr 0, req_ready 0, add_a 0, add_b 0, rsp_valid 0, rsp_sum 0, rsp_id 0.
REQ-029 Reset mid-operation SHALL discard the in-flight operation; no response is produced after reset release.

Configuration
REQ-030 Macro ADDER_SCHED_STATS_EN defined: SHALL add output grant_cnt (NUM_REQ*8), per-requester 8-bit counters incremented on each grant, saturating at 255, cleared by reset.
REQ-031 Macro undefined: SHALL have no grant_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-032 Package adder_sched_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP) and the default NUM_REQ/WIDTH constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector and ptr, outputs one-hot grant and index), instantiated once.

Verification
REQ-034 Single request: req_valid=0001, a=3, b=4 -> req_ready=0001 same cycle, rsp_valid 2 cycles later, rsp_sum=7, rsp_id=0.
REQ-035 All requesting continuously, ptr=0, rsp_ready=1 -> grants in order 0,1,2,3,0, one grant every 3 cycles.
REQ-036 Overflow: a=15, b=1 on requester 2 -> rsp_sum=16, rsp_id=2.
REQ-037 Backpressure: rsp_ready held low 5 cycles -> rsp_valid/rsp_sum stable, req_ready stays 0 until one cycle after rsp_ready rises.
REQ-038 Reset asserted during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next grant starts at requester 0.
REQ-039 With ADDER_SCHED_STATS_EN: 300 grants to requester 1 -> grant_cnt slice 1 = 255, other slices 0.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder scheduler: FSM state encoding and
// default sizing constants.
package adder_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   cand;
    logic found;

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Adder scheduler: time-shares one external combinational adder among
// NUM_REQ requesters. Flow per operation is IDLE (grant) -> EXEC (adder
// settles, result captured) -> RESP (held until consumed).
// Handshakes: a request transfers on the cycle req_valid[i] and req_ready[i]
// are both high; a response transfers on the rising edge where rsp_valid and
// rsp_ready are both high. rsp_sum/rsp_id hold while rsp_valid waits.
// Optional feature: define ADDER_SCHED_STATS_EN to add per-requester
// saturating 8-bit grant counters on output grant_cnt.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_s,
    input  logic                       add_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH:0]             rsp_sum,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]       grant_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        grant_idx;
    logic                 fire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // A grant happens only in IDLE; rst_n gating forces req_ready low the
    // instant reset is asserted, since it is a same-cycle acceptance strobe.
    assign fire      = (state == IDLE) && (|req_valid);
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    // Scheduler FSM: grant and latch operands, capture adder result, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        add_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                        add_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                        rsp_id <= grant_idx;
                        ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= {add_c, add_s};
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_SCHED_STATS_EN
    logic [7:0] cnt [NUM_REQ];

    // Per-requester grant counters, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    // Pack counters onto the flat output, requester i at slice i.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*8 +: 8] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched (NUM_REQ=4, WIDTH=4) with a behavioural
// shared adder. Covers ADDER_SCHED_STATS_EN when that macro is defined.
module tb_adder_sched;

    localparam int NR = 4;
    localparam int W  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_a, req_b;
    logic [NR-1:0]   req_ready;
    logic [W-1:0]    add_a, add_b, add_s;
    logic            add_c;
    logic            rsp_valid, rsp_ready;
    logic [W:0]      rsp_sum;
    logic [1:0]      rsp_id;
`ifdef ADDER_SCHED_STATS_EN
    logic [NR*8-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    // Shared combinational adder outside the scheduler.
    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

    adder_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADDER_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_a;
        logic [3:0]  exp_b;
        logic [4:0]  exp_sum;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Pointer starts at 0 and advances to grant+1 after each vector.
        vecs[0] = '{4'b0001, 16'hABC3, 16'h5DE4, 4'b0001, 4'd3,  4'd4,  5'd7,  2'd0};
        vecs[1] = '{4'b0100, 16'h1F23, 16'h9187, 4'b0100, 4'd15, 4'd1,  5'd16, 2'd2};
        vecs[2] = '{4'b0011, 16'h0049, 16'h00F8, 4'b0001, 4'd9,  4'd8,  5'd17, 2'd0};
        vecs[3] = '{4'b1001, 16'h7002, 16'h6003, 4'b1000, 4'd7,  4'd6,  5'd13, 2'd3};
        vecs[4] = '{4'b1111, 16'hFFF0, 16'hFFF0, 4'b0001, 4'd0,  4'd0,  5'd0,  2'd0};
        vecs[5] = '{4'b1110, 16'h00A0, 16'h0050, 4'b0010, 4'd10, 4'd5,  5'd15, 2'd1};
        vecs[6] = '{4'b0010, 16'h00F0, 16'h00F0, 4'b0010, 4'd15, 4'd15, 5'd30, 2'd1};

        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_add_a",     32'(add_a),     32'h0);
        check("reset_add_b",     32'(add_b),     32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_sum",   32'(rsp_sum),   32'h0);
        check("reset_rsp_id",    32'(rsp_id),    32'h0);
        do_reset();

        // Table-driven single operations, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            rsp_ready = 1'b1;
            #1;
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            step();
            req_valid = '0;
            #1;
            check($sformatf("v%0d_exec_ready", i), 32'(req_ready), 32'h0);
            check($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 32'h0);
            check($sformatf("v%0d_add_a", i),      32'(add_a),     32'(vecs[i].exp_a));
            check($sformatf("v%0d_add_b", i),      32'(add_b),     32'(vecs[i].exp_b));
            step();
            check($sformatf("v%0d_rsp_valid", i),  32'(rsp_valid), 32'h1);
            check($sformatf("v%0d_rsp_sum", i),    32'(rsp_sum),   32'(vecs[i].exp_sum));
            check($sformatf("v%0d_rsp_id", i),     32'(rsp_id),    32'(vecs[i].exp_id));
            step();
            check($sformatf("v%0d_rsp_done", i),   32'(rsp_valid), 32'h0);
            check($sformatf("v%0d_hold_a", i),     32'(add_a),     32'(vecs[i].exp_a));
        end

        // No requests: nothing granted, nothing produced.
        req_valid = '0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("idle_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h0);
        end

        // Continuous requests from everyone: grants 0,1,2,3,0 every 3 cycles.
        do_reset();
        req_valid = 4'b1111;
        req_a     = 16'h4321;
        req_b     = 16'h1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            int k;
            #1;
            k = (c / 3) % 4;
            check($sformatf("rr_ready_c%0d", c), 32'(req_ready),
                  (c % 3 == 0) ? (32'h1 << k) : 32'h0);
            check($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), (c % 3 == 2) ? 32'h1 : 32'h0);
            if (c % 3 == 2) begin
                check($sformatf("rr_id_c%0d", c),  32'(rsp_id),  32'(k));
                check($sformatf("rr_sum_c%0d", c), 32'(rsp_sum), 32'(k + 2));
            end
            step();
        end

        // Backpressure: response held 5 cycles; requester 1 drops before grant.
        do_reset();
        req_valid = 4'b0001;
        req_a     = 16'h0305;
        req_b     = 16'h0406;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0011;
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'h0);
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_sum_c%0d", c),   32'(rsp_sum),   32'd11);
            check($sformatf("bp_id_c%0d", c),    32'(rsp_id),    32'd0);
            check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'h0);
            step();
        end
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        check("bp_rise_ready", 32'(req_ready), 32'h0);
        check("bp_rise_valid", 32'(rsp_valid), 32'h1);
        step();
        check("bp_after_valid", 32'(rsp_valid), 32'h0);
        check("bp_skip_grant",  32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        check("bp2_valid", 32'(rsp_valid), 32'h1);
        check("bp2_id",    32'(rsp_id),    32'd2);
        check("bp2_sum",   32'(rsp_sum),   32'd7);
        step();

        // Reset while in EXEC: everything clears at once, no late response.
        do_reset();
        req_valid = 4'b0100;
        req_a     = 16'h0A00;
        req_b     = 16'h0300;
        rsp_ready = 1'b1;
        #1;
        check("rst_grant2", 32'(req_ready), 32'b0100);
        step();
        check("rst_exec_add_a", 32'(add_a), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ready", 32'(req_ready), 32'h0);
        check("rst_async_add_a", 32'(add_a),     32'h0);
        check("rst_async_add_b", 32'(add_b),     32'h0);
        check("rst_async_valid", 32'(rsp_valid), 32'h0);
        check("rst_async_sum",   32'(rsp_sum),   32'h0);
        check("rst_async_id",    32'(rsp_id),    32'h0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rst_no_rsp_c%0d", c), 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'b1111;
        #1;
        check("rst_ptr_zero", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        step();

`ifdef ADDER_SCHED_STATS_EN
        // 300 grants to requester 1: its counter saturates, others stay 0.
        do_reset();
        check("stats_clear", 32'(grant_cnt), 32'h0);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        for (int c = 0; c < 900; c++) step();
        req_valid = '0;
        step();
        for (int i = 0; i < NR; i++) begin
            check($sformatf("stats_cnt%0d", i), 32'(grant_cnt[i*8 +: 8]), (i == 1) ? 32'd255 : 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
